instruction_sequencer: RTL and testbench

Initiator side of the datapath's `start`/`finished` instruction handshake. Buffers instructions pushed by an upstream producer in a small FIFO and issues them one at a time to the datapath. It holds each instruction stable until the datapath reports completion. It filters opcodes the datapath cannot complete, because an unsupported opcode would otherwise leave `finished` low forever.

---
 rtl/instruction_sequencer_pkg.sv | 19 +
 rtl/instruction_sequencer_fifo.sv | 48 ++++
 rtl/instruction_sequencer.sv | 134 +++++++++++++
 tb/tb_instruction_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared widths, opcode values and FSM state type for the instruction sequencer.
package instruction_sequencer_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 22;
  localparam int unsigned OPCODE_WIDTH      = 3;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_PLOT = 3'd1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  function automatic logic is_supported(input logic [INSTRUCTION_WIDTH-1:0] instr);
    return instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] == OPCODE_PLOT;
  endfunction

endpackage

// File: rtl/instruction_sequencer_fifo.sv
// Synchronous FIFO without bypass; refuses pushes when full and ignores pops when empty.
module instruction_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data,
  input  logic                     push,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Issues buffered instructions to the datapath over start/finished, dropping unsupported opcodes.
// Optional watchdog compiled in with SEQUENCER_TIMEOUT_EN.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         start,
  input  logic                         finished,
  output logic                         busy,
  output logic [15:0]                  dropped_count,
  output logic                         timeout_error
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t                       state;
  logic [INSTRUCTION_WIDTH-1:0] head;
  logic                         full;
  logic                         empty;
  logic [CW-1:0]                count;
  logic [CW-1:0]                count_next;
  logic                         push;
  logic                         pop;
  logic                         supported;
  logic                         timeout;

  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign supported = is_supported(head);

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:      pop = !empty && !supported;
      WAIT_DONE: pop = finished;
      default:   pop = 1'b0;
    endcase
    if (timeout) pop = 1'b1;
  end

  assign count_next = count + CW'(push) - CW'(pop && !empty);

  instruction_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(INSTRUCTION_WIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .data  (in_instruction),
    .push  (push),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head),
    .count (count)
  );

  // busy defaults to 1 for the in-flight states; transitions into IDLE use post-edge occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      instruction   <= '0;
      start         <= 1'b0;
      busy          <= 1'b0;
      dropped_count <= '0;
    end else begin
      start <= 1'b0;
      busy  <= 1'b1;
      case (state)
        IDLE: begin
          busy <= count_next != '0;
          if (!empty) begin
            if (!supported) begin
              if (dropped_count != '1) dropped_count <= dropped_count + 1'b1;
            end else if (finished) begin
              instruction <= head;
              start       <= 1'b1;
              busy        <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (timeout) begin
            busy  <= count_next != '0;
            state <= IDLE;
          end else if (!finished) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (finished || timeout) begin
            busy  <= count_next != '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQUENCER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer;
  logic          waiting;

  assign waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign timeout = waiting && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      timer         <= '0;
      timeout_error <= 1'b0;
    end else begin
      timer <= waiting ? timer + 1'b1 : '0;
      if (timeout) timeout_error <= 1'b1;
    end
  end
`else
  assign timeout       = 1'b0;
  assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: stimulus queues expected issues, a negedge monitor checks each start pulse.
module tb_instruction_sequencer;
  import instruction_sequencer_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic [INSTRUCTION_WIDTH-1:0] in_instruction = '0;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         start;
  logic                         finished;
  logic                         busy;
  logic [15:0]                  dropped_count;
  logic                         timeout_error;

  int n_checks = 0;
  int n_fail   = 0;
  int start_count = 0;
  logic [INSTRUCTION_WIDTH-1:0] exp_q[$];
  logic [INSTRUCTION_WIDTH-1:0] last_issued = '0;

  int   dp_cnt = 0;
  int   dp_len = 2;
  logic dp_force_low = 1'b0;

  instruction_sequencer #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_instruction (in_instruction),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instruction    (instruction),
    .start          (start),
    .finished       (finished),
    .busy           (busy),
    .dropped_count  (dropped_count),
    .timeout_error  (timeout_error)
  );

  always #5 clock = ~clock;

  // Datapath model: finished drops for dp_len cycles after each start.
  always @(posedge clock) begin
    if (reset) dp_cnt <= 0;
    else if (start) dp_cnt <= dp_len;
    else if (dp_cnt != 0) dp_cnt <= dp_cnt - 1;
  end
  assign finished = !dp_force_low && (dp_cnt == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [INSTRUCTION_WIDTH-1:0] mk(input logic [2:0] op, input logic [7:0] x,
                                                     input logic [6:0] y, input logic [2:0] col);
    return {op, x, y, col, 1'b1};
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (start) begin
        start_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(instruction), 32'h7fffffff);
        end else begin
          last_issued = exp_q.pop_front();
          check("issued_instruction", 32'(instruction), 32'(last_issued));
        end
      end else if (dp_cnt != 0) begin
        check("instruction_stable", 32'(instruction), 32'(last_issued));
      end
    end
  end

  // Call at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic push_instr(input logic [INSTRUCTION_WIDTH-1:0] v);
    int unsigned n = 0;
    in_instruction = v;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) begin
      check("push_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (is_supported(v)) exp_q.push_back(v);
    end
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned n = 0;
    while (busy && n < limit) begin
      @(posedge clock); #1;
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic wait_start(input int unsigned limit);
    int unsigned n = 0;
    while (!start && n < limit) begin
      @(posedge clock); #1;
      n++;
    end
    check("start_seen", 32'(start), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [INSTRUCTION_WIDTH-1:0] p;

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_instruction", 32'(instruction), 32'd0);
    check("reset_start", 32'(start), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_dropped", 32'(dropped_count), 32'd0);
    check("reset_timeout", 32'(timeout_error), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Single plot instruction: start during the second cycle after the push.
    p = mk(3'd1, 8'h10, 7'h05, 3'b101);
    push_instr(p);
    check("t1_start_n1", 32'(start), 32'd0);
    @(posedge clock); #1;
    check("t1_start_n2", 32'(start), 32'd1);
    check("t1_instruction", 32'(instruction), 32'(p));
    @(posedge clock); #1;
    check("t1_start_n3", 32'(start), 32'd0);
    wait_idle(50);
    check("t1_start_count", 32'(start_count), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);

    // Two unsupported opcodes dropped, then one plot.
    base = start_count;
    push_instr(mk(3'd0, 8'h01, 7'h01, 3'd1));
    push_instr(mk(3'd3, 8'h02, 7'h02, 3'd2));
    push_instr(mk(3'd1, 8'h33, 7'h44, 3'd3));
    wait_idle(50);
    check("t2_dropped", 32'(dropped_count), 32'd2);
    check("t2_starts", 32'(start_count - base), 32'd1);

    // Fill the FIFO with the datapath held busy; the 17th waits for the first pop.
    base = start_count;
    dp_force_low = 1'b1;
    for (int i = 0; i < 16; i++) push_instr(mk(3'd1, 8'(i), 7'(i), 3'(i)));
    check("t3_full_in_ready", 32'(in_ready), 32'd0);
    check("t3_no_issue_while_busy", 32'(start_count - base), 32'd0);
    fork
      begin
        push_instr(mk(3'd1, 8'hAA, 7'h55, 3'd7));
        check("t3_accept_after_pop", 32'(start_count - base), 32'd1);
      end
      begin
        repeat (4) @(posedge clock);
        #1;
        dp_force_low = 1'b0;
      end
    join
    wait_idle(17 * 6 + 50);
    check("t3_starts", 32'(start_count - base), 32'd17);
    check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // finished low at issue time blocks start, then the normal wait sequence follows.
    base = start_count;
    dp_force_low = 1'b1;
    p = mk(3'd1, 8'h77, 7'h11, 3'd4);
    push_instr(p);
    repeat (6) @(posedge clock);
    #1;
    check("t4_no_start_while_low", 32'(start_count - base), 32'd0);
    dp_force_low = 1'b0;
    wait_start(10);
    repeat (3) @(posedge clock);
    #1;
    check("t4_busy_in_wait_done", 32'(busy), 32'd1);
    check("t4_instruction_held", 32'(instruction), 32'(p));
    @(posedge clock); #1;
    check("t4_busy_after_pop", 32'(busy), 32'd0);
    check("t4_starts", 32'(start_count - base), 32'd1);

    // Reset during WAIT_DONE with three entries queued behind the in-flight one.
    base = start_count;
    dp_len = 50;
    for (int i = 0; i < 4; i++) push_instr(mk(3'd1, 8'hC0 + 8'(i), 7'(i), 3'd2));
    repeat (3) @(posedge clock);
    #1;
    check("t5_one_issued", 32'(start_count - base), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    dp_len = 2;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_start", 32'(start), 32'd0);
    check("t5_dropped", 32'(dropped_count), 32'd0);
    repeat (30) @(posedge clock);
    #1;
    check("t5_no_reissue", 32'(start_count - base), 32'd1);
    check("t5_still_idle", 32'(busy), 32'd0);

`ifdef SEQUENCER_TIMEOUT_EN
    // Datapath never completes the first: watchdog pops it after 8 wait cycles.
    base = start_count;
    push_instr(mk(3'd1, 8'hE1, 7'h21, 3'd1));
    push_instr(mk(3'd1, 8'hE2, 7'h22, 3'd2));
    wait_start(10);
    dp_force_low = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("t6_timeout_not_yet", 32'(timeout_error), 32'd0);
    @(posedge clock); #1;
    check("t6_timeout_set", 32'(timeout_error), 32'd1);
    dp_force_low = 1'b0;
    wait_idle(50);
    check("t6_starts", 32'(start_count - base), 32'd2);
    check("t6_timeout_sticky", 32'(timeout_error), 32'd1);
`else
    check("timeout_tied_low", 32'(timeout_error), 32'd0);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
